dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port, byte-addressed, big-endian data memory.
- Requester 0 is the core load/store stage. Requester 1 is the test/DMA loader.
- Grants one requester at a time using round-robin and drives the memory strobes for a fixed multi-cycle access.
- Returns read data with a one-cycle ack pulse. Rejects misaligned and out-of-range accesses without touching memory.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/rr_arbiter_2.sv | 43 ++++
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the data-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Sequencer states: waiting for a request, driving memory, acknowledging
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Low address bits that must be zero for a word access
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // Default memory geometry and access latency
    localparam int DEF_MEM_BYTES = 256;
    localparam int DEF_MEM_LAT   = 2;

    // Requester indices within the request/grant vectors
    localparam int REQ_CORE   = 0;
    localparam int REQ_LOADER = 1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_2
//  Description : Two-way round-robin arbiter. Produces a one-hot grant from
//                the current requests; the pointer flips only when both
//                requesters contend and the grant is taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_gnt
);

    // 0 favours the core, 1 favours the loader
    logic r_ptr;

    // One-hot grant: a lone requester always wins, a tie goes to the pointer
    always_comb begin
        o_gnt = 2'b00;
        if (i_req == 2'b11) begin
            o_gnt[REQ_CORE]   = ~r_ptr;
            o_gnt[REQ_LOADER] = r_ptr;
        end else begin
            o_gnt = i_req;
        end
    end

    // After a contended grant, hand priority to the requester that lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_update && (i_req == 2'b11)) begin
            r_ptr <= ~r_ptr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Arbitrates the core and the loader onto the single-port data
//                memory, sequences a fixed-latency access and returns a
//                one-cycle ack with read data or an error for illegal
//                addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = DEF_MEM_BYTES,
    parameter int MEM_LAT   = DEF_MEM_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_ack,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_ack,
    output logic              r1_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_read,
    output logic              mem_write
);

    localparam int                  C_CNT_W    = $clog2(MEM_LAT) + 1;
    localparam logic [ADDR_W-1:0]   C_MAX_ADDR = ADDR_W'(MEM_BYTES - 4);
    localparam logic [C_CNT_W-1:0]  C_CNT_INIT = C_CNT_W'(MEM_LAT - 1);
    localparam logic [C_CNT_W-1:0]  C_CNT_ONE  = C_CNT_W'(1);

    state_t              r_state;
    logic [C_CNT_W-1:0]  r_cnt;
    logic                r_gnt;      // 0 = core, 1 = loader
    logic                r_we;

    logic [1:0]          w_req;
    logic [1:0]          w_gnt;
    logic                w_update;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_legal;

    assign w_req[REQ_CORE]   = r0_req;
    assign w_req[REQ_LOADER] = r1_req;
    assign w_update          = (r_state == IDLE);

    rr_arbiter_2 u_rr (
        .clk      (clk),
        .rst      (reset),
        .i_req    (w_req),
        .i_update (w_update),
        .o_gnt    (w_gnt)
    );

    // Fields of whichever requester the arbiter picked this cycle
    assign w_sel_we    = w_gnt[REQ_LOADER] ? r1_we    : r0_we;
    assign w_sel_addr  = w_gnt[REQ_LOADER] ? r1_addr  : r0_addr;
    assign w_sel_wdata = w_gnt[REQ_LOADER] ? r1_wdata : r0_wdata;

    // Word aligned and the whole word inside memory, compared at full width
    assign w_legal = ((w_sel_addr[1:0] & ALIGN_MASK) == 2'b00) &&
                     (w_sel_addr <= C_MAX_ADDR);

    // Sequencer: grant, hold the memory strobes for the access, then ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_gnt       <= 1'b0;
            r_we        <= 1'b0;
            r0_rdata    <= '0;
            r0_ack      <= 1'b0;
            r0_err      <= 1'b0;
            r1_rdata    <= '0;
            r1_ack      <= 1'b0;
            r1_err      <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_gnt) begin
                        r_gnt <= w_gnt[REQ_LOADER];
                        r_we  <= w_sel_we;
                        if (w_legal) begin
                            mem_address <= w_sel_addr;
                            mem_data_in <= w_sel_wdata;
                            mem_read    <= ~w_sel_we;
                            mem_write   <= w_sel_we;
                            r_cnt       <= C_CNT_INIT;
                            r_state     <= ACCESS;
                        end else begin
                            // Rejected without touching memory
                            if (w_gnt[REQ_LOADER]) begin
                                r1_ack <= 1'b1;
                                r1_err <= 1'b1;
                            end else begin
                                r0_ack <= 1'b1;
                                r0_err <= 1'b1;
                            end
                            r_state <= DONE;
                        end
                    end
                end
                ACCESS: begin
                    // Write strobe is a single-cycle pulse
                    mem_write <= 1'b0;
                    if (r_cnt == '0) begin
                        mem_read <= 1'b0;
                        if (r_gnt) begin
                            r1_ack <= 1'b1;
                            if (!r_we) begin
                                r1_rdata <= mem_data_out;
                            end
                        end else begin
                            r0_ack <= 1'b1;
                            if (!r_we) begin
                                r0_rdata <= mem_data_out;
                            end
                        end
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - C_CNT_ONE;
                    end
                end
                DONE: begin
                    r0_ack  <= 1'b0;
                    r0_err  <= 1'b0;
                    r1_ack  <= 1'b0;
                    r1_err  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter with a transaction-level
//                reference model, a word-array memory and directed plus
//                randomized requester traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_BYTES = 256;
    localparam int MEM_LAT   = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              r0_req = 1'b0, r0_we = 1'b0;
    logic [ADDR_W-1:0] r0_addr = '0;
    logic [DATA_W-1:0] r0_wdata = '0;
    logic [DATA_W-1:0] r0_rdata;
    logic              r0_ack, r0_err;
    logic              r1_req = 1'b0, r1_we = 1'b0;
    logic [ADDR_W-1:0] r1_addr = '0;
    logic [DATA_W-1:0] r1_wdata = '0;
    logic [DATA_W-1:0] r1_rdata;
    logic              r1_ack, r1_err;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_read, mem_write;

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_rdata(r0_rdata), .r0_ack(r0_ack), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_rdata(r1_rdata), .r1_ack(r1_ack), .r1_err(r1_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_read(mem_read), .mem_write(mem_write)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 2) return 32'hDEADBEEF;
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    // Memory seen by the DUT: asynchronous read, write commits at the edge
    logic [31:0] bmem [64];
    assign mem_data_out = bmem[mem_address[7:2]];
    initial begin
        for (int i = 0; i < 64; i++) bmem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_write) bmem[mem_address[7:2]] = mem_data_in;
        end
    end

    // ---------------- transaction-level reference model ----------------
    int          cyc = 0;           // number of active edges since reset
    int          m_ptr = 0;         // which requester wins a tie
    bit          m_valid = 0;
    int          m_gnt = 0;
    bit          m_we = 0, m_legal = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    int          m_start = 0, m_ack_edge = 0, m_next = 0;
    logic [31:0] exp_rdata [2];
    logic [31:0] ref_mem [64];

    initial begin
        int w;
        logic [31:0] a;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_valid = 0; m_ptr = 0; m_next = 0;
                exp_rdata[0] = '0; exp_rdata[1] = '0;
            end else begin
                cyc++;
                if (m_valid && cyc == m_ack_edge && m_legal && !m_we)
                    exp_rdata[m_gnt] = m_rdata;
                if (cyc >= m_next && (r0_req || r1_req)) begin
                    if (r0_req && r1_req) begin
                        w = m_ptr;
                        m_ptr = 1 - w;
                    end else begin
                        w = r1_req ? 1 : 0;
                    end
                    a        = (w == 0) ? r0_addr : r1_addr;
                    m_gnt    = w;
                    m_addr   = a;
                    m_we     = (w == 0) ? r0_we : r1_we;
                    m_wdata  = (w == 0) ? r0_wdata : r1_wdata;
                    m_legal  = ((a % 32'd4) == 0) && (longint'(a) <= longint'(MEM_BYTES - 4));
                    m_start  = cyc;
                    m_ack_edge = cyc + (m_legal ? MEM_LAT : 0);
                    m_next   = m_ack_edge + 2;
                    m_valid  = 1;
                    if (m_legal) begin
                        if (m_we) ref_mem[a / 4] = m_wdata;
                        else      m_rdata = ref_mem[a / 4];
                    end
                end
            end
        end
    end

    // ---------------- observation log ----------------
    int ack_log [$];
    int n_rd_cyc = 0, n_wr_cyc = 0;
    initial forever begin
        @(negedge clk);
        if (r0_ack) ack_log.push_back(0);
        if (r1_ack) ack_log.push_back(1);
        if (mem_read)  n_rd_cyc++;
        if (mem_write) n_wr_cyc++;
    end

    // ---------------- checking ----------------
    int n_total = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, output int waited,
                          output logic err, output logic [31:0] rd);
        logic got;
        got = 0; waited = 0; err = 0; rd = '0;
        if (k == 0) begin r0_req = 1; r0_we = we; r0_addr = addr; r0_wdata = wd; end
        else        begin r1_req = 1; r1_we = we; r1_addr = addr; r1_wdata = wd; end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk); #1;
            waited++;
            if ((k == 0) ? r0_ack : r1_ack) begin
                got = 1;
                err = (k == 0) ? r0_err : r1_err;
                rd  = (k == 0) ? r0_rdata : r1_rdata;
            end
        end
        if (k == 0) r0_req = 0; else r1_req = 0;
        chk("ack_seen", 64'(got), 64'd1);
    endtask

    function automatic logic [31:0] pick_addr();
        int sel;
        sel = int'($urandom_range(0, 9));
        case (sel)
            0: return 32'h0000_00FC;
            1: return 32'h0000_0100;
            2: return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
            3: return 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2);
            default: return 32'($urandom_range(0, 63)) << 2;
        endcase
    endfunction

    initial begin
        int          lat, base, rd0, wr0, cnt1;
        logic        err;
        logic [31:0] rd;

        // Every-cycle comparison of the DUT against the model
        fork
            begin : cmp
                int e;
                bit x_rd, x_wr, x_a0, x_a1;
                forever begin
                    @(negedge clk);
                    if (reset) begin
                        chk("rst_r0_ack", 64'(r0_ack), 0);
                        chk("rst_r1_ack", 64'(r1_ack), 0);
                        chk("rst_r0_err", 64'(r0_err), 0);
                        chk("rst_r1_err", 64'(r1_err), 0);
                        chk("rst_r0_rdata", 64'(r0_rdata), 0);
                        chk("rst_r1_rdata", 64'(r1_rdata), 0);
                        chk("rst_mem_read", 64'(mem_read), 0);
                        chk("rst_mem_write", 64'(mem_write), 0);
                        chk("rst_mem_address", 64'(mem_address), 0);
                        chk("rst_mem_data_in", 64'(mem_data_in), 0);
                    end else begin
                        e    = cyc;
                        x_rd = m_valid && m_legal && !m_we && e >= m_start && e < m_start + MEM_LAT;
                        x_wr = m_valid && m_legal && m_we && e == m_start;
                        x_a0 = m_valid && m_gnt == 0 && e == m_ack_edge;
                        x_a1 = m_valid && m_gnt == 1 && e == m_ack_edge;
                        chk("mem_read", 64'(mem_read), 64'(x_rd));
                        chk("mem_write", 64'(mem_write), 64'(x_wr));
                        chk("r0_ack", 64'(r0_ack), 64'(x_a0));
                        chk("r1_ack", 64'(r1_ack), 64'(x_a1));
                        chk("r0_err", 64'(r0_err), 64'(x_a0 && !m_legal));
                        chk("r1_err", 64'(r1_err), 64'(x_a1 && !m_legal));
                        chk("r0_rdata", 64'(r0_rdata), 64'(exp_rdata[0]));
                        chk("r1_rdata", 64'(r1_rdata), 64'(exp_rdata[1]));
                        if (x_rd || x_wr) chk("mem_address", 64'(mem_address), 64'(m_addr));
                        if (x_wr)         chk("mem_data_in", 64'(mem_data_in), 64'(m_wdata));
                    end
                end
            end
        join_none

        #1 reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_r0_rdata", 64'(r0_rdata), 64'h0);
        chk("reset_mem_read", 64'(mem_read), 64'h0);
        @(posedge clk); #2 reset = 0;
        idle(1);

        // Single read of 0x08
        rd0 = n_rd_cyc;
        do_req(0, 1'b0, 32'h08, 32'h0, lat, err, rd);
        chk("read_latency", 64'(lat), 64'd3);
        chk("read_data", 64'(rd), 64'hDEADBEEF);
        chk("read_err", 64'(err), 64'd0);
        chk("read_strobe_cycles", 64'(n_rd_cyc - rd0), 64'd2);
        idle(2);

        // Write then read back through the loader
        wr0 = n_wr_cyc;
        do_req(1, 1'b1, 32'h10, 32'h12345678, lat, err, rd);
        chk("write_latency", 64'(lat), 64'd3);
        chk("write_strobe_cycles", 64'(n_wr_cyc - wr0), 64'd1);
        idle(2);
        do_req(1, 1'b0, 32'h10, 32'h0, lat, err, rd);
        chk("readback_data", 64'(rd), 64'h12345678);
        idle(2);

        // Misaligned and out-of-range accesses
        rd0 = n_rd_cyc; wr0 = n_wr_cyc;
        do_req(0, 1'b0, 32'h0A, 32'h0, lat, err, rd);
        chk("misalign_latency", 64'(lat), 64'd1);
        chk("misalign_err", 64'(err), 64'd1);
        chk("misalign_rdata_kept", 64'(rd), 64'hDEADBEEF);
        idle(2);
        do_req(0, 1'b0, 32'hFE, 32'h0, lat, err, rd);
        chk("range_latency", 64'(lat), 64'd1);
        chk("range_err", 64'(err), 64'd1);
        chk("illegal_no_strobes", 64'((n_rd_cyc - rd0) + (n_wr_cyc - wr0)), 64'd0);
        idle(2);

        // Contention: both requesters hold requests for two transactions each
        base = ack_log.size();
        fork
            begin
                int l; logic ee; logic [31:0] dd;
                do_req(0, 1'b0, 32'h08, 32'h0, l, ee, dd);
                do_req(0, 1'b0, 32'h08, 32'h0, l, ee, dd);
            end
            begin
                int l; logic ee; logic [31:0] dd;
                do_req(1, 1'b0, 32'h10, 32'h0, l, ee, dd);
                do_req(1, 1'b0, 32'h10, 32'h0, l, ee, dd);
            end
        join
        chk("contend_count", 64'(ack_log.size() - base), 64'd4);
        if (ack_log.size() >= base + 4) begin
            chk("contend_order0", 64'(ack_log[base]),     64'd0);
            chk("contend_order1", 64'(ack_log[base + 1]), 64'd1);
            chk("contend_order2", 64'(ack_log[base + 2]), 64'd0);
            chk("contend_order3", 64'(ack_log[base + 3]), 64'd1);
        end
        idle(2);

        // Reset during the loader's first access cycle
        base = ack_log.size();
        r1_req = 1; r1_we = 0; r1_addr = 32'h20;
        @(posedge clk); #1;
        chk("access_before_reset", 64'(mem_read), 64'd1);
        #1 reset = 1;
        #1;
        chk("midrst_r1_ack", 64'(r1_ack), 64'd0);
        chk("midrst_mem_read", 64'(mem_read), 64'd0);
        chk("midrst_mem_address", 64'(mem_address), 64'd0);
        chk("midrst_r0_rdata", 64'(r0_rdata), 64'd0);
        r1_req = 0;
        @(posedge clk); #2 reset = 0;
        idle(1);
        fork
            begin int l; logic ee; logic [31:0] dd; do_req(0, 1'b0, 32'h08, 32'h0, l, ee, dd); end
            begin int l; logic ee; logic [31:0] dd; do_req(1, 1'b0, 32'h0C, 32'h0, l, ee, dd); end
        join
        chk("post_reset_acks", 64'(ack_log.size() - base), 64'd2);
        if (ack_log.size() > base) chk("post_reset_first", 64'(ack_log[base]), 64'd0);
        idle(2);

        // Loader drops its request during the access
        base = ack_log.size();
        r1_req = 1; r1_we = 0; r1_addr = 32'h08;
        @(posedge clk);
        @(negedge clk); #1;
        r1_req = 0;
        idle(8);
        cnt1 = 0;
        for (int i = base; i < ack_log.size(); i++) if (ack_log[i] == 1) cnt1++;
        chk("drop_single_ack", 64'(cnt1), 64'd1);
        chk("drop_rdata", 64'(r1_rdata), 64'hDEADBEEF);

        // Randomized traffic from both requesters
        fork
            begin
                int l; logic ee; logic [31:0] dd;
                for (int i = 0; i < 30; i++) begin
                    idle(int'($urandom_range(0, 3)));
                    do_req(0, 1'($urandom_range(0, 1)), pick_addr(), $urandom, l, ee, dd);
                end
            end
            begin
                int l; logic ee; logic [31:0] dd;
                for (int j = 0; j < 30; j++) begin
                    idle(int'($urandom_range(0, 3)));
                    do_req(1, 1'($urandom_range(0, 1)), pick_addr(), $urandom, l, ee, dd);
                end
            end
        join
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
